// File: rtl/uart_tx_fifo.sv
// Transmit byte queue feeding the UART transmitter through a txd/tx_vld/tx_done
// four-phase handshake; the byte is popped when its handshake launches.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  wr_full,
  input  logic                  flush,
  input  logic                  ovf_clr,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  tx_busy,
  output logic                  tx_idle,
  output logic [7:0]            txd,
  output logic                  tx_vld,
  input  logic                  tx_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [7:0]      mem_r [DEPTH];
  logic [7:0]      txd_r;
  logic [7:0]      txd_next_s;
  logic            tx_vld_r;
  logic            tx_vld_next_s;
  logic            overflow_r;
  logic [PW-1:0]   level_s;
  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            ovf_set_s;
  logic            can_launch_s;
  logic            launch_s;

  assign level_s   = wr_ptr_r - rd_ptr_r;
  assign full_s    = (level_s == PW'(DEPTH));
  assign empty_s   = (level_s == {PW{1'b0}});
  assign push_s    = wr_en && !full_s && !flush;
  // A push coinciding with flush is discarded silently, not counted as overflow.
  assign ovf_set_s = wr_en && full_s && !flush;
  // tx_done is also gated here so tx_vld can never rise against a stuck-high done.
  assign can_launch_s = !empty_s && !flush && !tx_done;

  assign wr_full  = full_s;
  assign level    = level_s;
  assign overflow = overflow_r;
  assign txd      = txd_r;
  assign tx_vld   = tx_vld_r;
  assign tx_busy  = (state_r != S_IDLE);
  assign tx_idle  = empty_s && (state_r == S_IDLE);

  // Storage array: written on accepted pushes, never reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  // Pointers and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (flush) begin
        rd_ptr_r <= wr_ptr_r;
      end else if (launch_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Handshake state and registered transmitter outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= S_IDLE;
      txd_r    <= 8'h00;
      tx_vld_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      txd_r    <= txd_next_s;
      tx_vld_r <= tx_vld_next_s;
    end
  end

  // Next-state decode for the handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (can_launch_s) state_next_s = S_REQ;
        else              state_next_s = S_IDLE;
      end
      S_REQ: begin
        if (tx_done) state_next_s = S_ACK;
        else         state_next_s = S_REQ;
      end
      S_ACK: begin
        if (!tx_done) state_next_s = S_IDLE;
        else          state_next_s = S_ACK;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Output decode: launch pops the head byte into txd.
  always_comb begin
    txd_next_s    = txd_r;
    tx_vld_next_s = tx_vld_r;
    launch_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (can_launch_s) begin
          launch_s      = 1'b1;
          txd_next_s    = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
          tx_vld_next_s = 1'b1;
        end else begin
          tx_vld_next_s = 1'b0;
        end
      end
      S_REQ: begin
        if (tx_done) tx_vld_next_s = 1'b0;
        else         tx_vld_next_s = 1'b1;
      end
      S_ACK:   tx_vld_next_s = 1'b0;
      default: tx_vld_next_s = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table for push/launch/level timing
// plus hand-written sequences for fill/overflow, flush and async reset.
module tb_uart_tx_fifo;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_full;
  logic       flush;
  logic       ovf_clr;
  logic       overflow;
  logic [4:0] level;
  logic       tx_busy;
  logic       tx_idle;
  logic [7:0] txd;
  logic       tx_vld;
  logic       tx_done;

  int pass_cnt;
  int total_cnt;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .flush(flush), .ovf_clr(ovf_clr), .overflow(overflow),
    .level(level), .tx_busy(tx_busy), .tx_idle(tx_idle), .txd(txd),
    .tx_vld(tx_vld), .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       ovf_clr;
    logic       tx_done;
    logic       exp_vld;
    logic [7:0] exp_txd;
    logic [4:0] exp_level;
    logic       exp_full;
    logic       exp_ovf;
    logic       exp_idle;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; ovf_clr = 1'b0; tx_done = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Transmitter model: wait for tx_vld, check the byte, hold tx_done for 'hold' cycles.
  task automatic serve(input logic [7:0] exp, input int hold);
    int n;
    n = 0;
    while (!tx_vld && n < 50) begin tick(); n++; end
    check("vld_timeout", {31'd0, tx_vld}, 32'd1);
    check("txd_order", {24'd0, txd}, {24'd0, exp});
    tx_done = 1'b1;
    tick();
    check("vld_drop", {31'd0, tx_vld}, 32'd0);
    for (int i = 1; i < hold; i++) begin
      tick();
      check("vld_under_done", {31'd0, tx_vld}, 32'd0);
    end
    tx_done = 1'b0;
    tick();
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;

    //       wr  data   fl   clr  done   vld  txd    lvl    full  ovf   idle
    vecs[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 5'd2, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 5'd3, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA1, 5'd3, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA1, 5'd3, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA2, 5'd3, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA2, 5'd3, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA2, 5'd3, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA2, 5'd3, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA3, 5'd2, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 5'd2, 1'b0, 1'b0, 1'b0};

    reset_n = 1'b0;
    wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; ovf_clr = 1'b0; tx_done = 1'b0;
    tick();
    tick();
    check("rst_vld",   {31'd0, tx_vld},   32'd0);
    check("rst_txd",   {24'd0, txd},      32'd0);
    check("rst_level", {27'd0, level},    32'd0);
    check("rst_full",  {31'd0, wr_full},  32'd0);
    check("rst_ovf",   {31'd0, overflow}, 32'd0);
    check("rst_busy",  {31'd0, tx_busy},  32'd0);
    check("rst_idle",  {31'd0, tx_idle},  32'd1);
    reset_n = 1'b1;
    tick();

    // Table: push/launch overlap, long tx_done pulse, push during launch at level 3.
    for (int i = 0; i < 12; i++) begin
      wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data; flush = vecs[i].flush;
      ovf_clr = vecs[i].ovf_clr; tx_done = vecs[i].tx_done;
      tick();
      check($sformatf("v%0d_vld", i),   {31'd0, tx_vld},   {31'd0, vecs[i].exp_vld});
      check($sformatf("v%0d_txd", i),   {24'd0, txd},      {24'd0, vecs[i].exp_txd});
      check($sformatf("v%0d_level", i), {27'd0, level},    {27'd0, vecs[i].exp_level});
      check($sformatf("v%0d_full", i),  {31'd0, wr_full},  {31'd0, vecs[i].exp_full});
      check($sformatf("v%0d_ovf", i),   {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
      check($sformatf("v%0d_idle", i),  {31'd0, tx_idle},  {31'd0, vecs[i].exp_idle});
    end
    wr_en = 1'b0; ovf_clr = 1'b0; tx_done = 1'b0;
    serve(8'hA3, 1);
    serve(8'hA4, 2);
    serve(8'hA5, 1);
    check("table_drain_idle", {31'd0, tx_idle}, 32'd1);

    // Single byte: one-cycle launch latency, long wait before tx_done.
    do_reset();
    push(8'h55);
    check("t1_vld_n", {31'd0, tx_vld}, 32'd0);
    tick();
    check("t1_vld_n1", {31'd0, tx_vld}, 32'd1);
    check("t1_txd", {24'd0, txd}, 32'h55);
    for (int i = 0; i < 20; i++) tick();
    check("t1_vld_hold", {31'd0, tx_vld}, 32'd1);
    tx_done = 1'b1;
    tick();
    check("t1_vld_drop", {31'd0, tx_vld}, 32'd0);
    tx_done = 1'b0;
    tick();
    check("t1_idle", {31'd0, tx_idle}, 32'd1);
    check("t1_level", {27'd0, level}, 32'd0);

    // Fill to capacity, overflow, set-wins-over-clear, then drain in order.
    do_reset();
    for (int i = 0; i < 17; i++) push(8'h10 + 8'(i));
    check("t2_level", {27'd0, level}, 32'd16);
    check("t2_full", {31'd0, wr_full}, 32'd1);
    check("t2_inflight", {24'd0, txd}, 32'h10);
    check("t2_no_ovf", {31'd0, overflow}, 32'd0);
    push(8'hEE);
    check("t2_ovf", {31'd0, overflow}, 32'd1);
    check("t2_level_keep", {27'd0, level}, 32'd16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t2_ovf_clr", {31'd0, overflow}, 32'd0);
    wr_en = 1'b1; wr_data = 8'hEF; ovf_clr = 1'b1;
    tick();
    wr_en = 1'b0; ovf_clr = 1'b0;
    check("t2_set_wins", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 17; i++) serve(8'h10 + 8'(i), 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_no_extra", {31'd0, tx_vld}, 32'd0);
    end
    check("t2_empty", {27'd0, level}, 32'd0);

    // Flush during S_REQ with a same-cycle push.
    do_reset();
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    check("t4_level_pre", {27'd0, level}, 32'd5);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hFF;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    check("t4_level_flush", {27'd0, level}, 32'd0);
    check("t4_inflight", {31'd0, tx_vld}, 32'd1);
    check("t4_no_ovf", {31'd0, overflow}, 32'd0);
    serve(8'hC0, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t4_no_vld", {31'd0, tx_vld}, 32'd0);
    end
    check("t4_idle", {31'd0, tx_idle}, 32'd1);

    // Asynchronous reset in S_REQ with overflow set.
    do_reset();
    for (int i = 0; i < 18; i++) push(8'h30 + 8'(i));
    check("t6_pre_vld", {31'd0, tx_vld}, 32'd1);
    check("t6_pre_ovf", {31'd0, overflow}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_vld", {31'd0, tx_vld}, 32'd0);
    check("t6_async_ovf", {31'd0, overflow}, 32'd0);
    #2;
    reset_n = 1'b1;
    tick();
    check("t6_level", {27'd0, level}, 32'd0);
    check("t6_idle", {31'd0, tx_idle}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
